// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan controller.
//   scan_state_t : sequencer state (BLANK = all anodes off, SHOW = one digit lit)
//   digit_t      : one 4-bit hex digit register
//   SEG_OFF      : all segments dark (active-low)
//   AN_OFF       : all anodes off (active-low)
package seg_pkg;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: write port plus display pins of the scan controller.
//   en         : display enable (low = dark, scan restarts)
//   wr_en      : digit register write strobe
//   wr_addr    : digit index to write (0 = rightmost)
//   wr_data    : hex value to store
//   dp_mask    : per-digit decimal point request, active-high
//   seg        : segments {A..G}, active-low
//   dp         : decimal point, active-low
//   an         : anodes, active-low, an[i] = digit i
//   digit_idx  : digit currently being scanned
//   frame_tick : one-cycle pulse at the start of each 4-digit frame
// master = driver of the write port / consumer of the pins, slave = controller.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic        en;
    logic        wr_en;
    logic [1:0]  wr_addr;
    digit_t      wr_data;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    modport master (
        output en, wr_en, wr_addr, wr_data, dp_mask,
        input  seg, dp, an, digit_idx, frame_tick
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, dp_mask,
        output seg, dp, an, digit_idx, frame_tick
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex digit to active-low seven-segment glyph.
//   i_digit : 4-bit hex value
//   o_seg   : segments {A,B,C,D,E,F,G}, active-low
module seg7_hex_decode
    import seg_pkg::*;
(
    input  digit_t     i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_digit)
            4'h0: o_seg = 7'b0000001;
            4'h1: o_seg = 7'b1001111;
            4'h2: o_seg = 7'b0010010;
            4'h3: o_seg = 7'b0000110;
            4'h4: o_seg = 7'b1001100;
            4'h5: o_seg = 7'b0100100;
            4'h6: o_seg = 7'b0100000;
            4'h7: o_seg = 7'b0001111;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0000100;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b1100000;
            4'hC: o_seg = 7'b0110001;
            4'hD: o_seg = 7'b1000010;
            4'hE: o_seg = 7'b0110000;
            4'hF: o_seg = 7'b0111000;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display. Four digit registers are lit one at a time (SHOW,
// REFRESH_DIV cycles) separated by an all-dark gap (BLANK, BLANK_CYC cycles).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seg_scan_ctrl_if.slave (write port in, display pins out)
// Optional build macro SEG_LEADING_ZERO_BLANK_EN: when defined, digits 3..1
// are dark while they and every more-significant digit are zero.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    scan_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_idx;
    digit_t [3:0]          r_reg;

    scan_state_t           w_state_nx;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic [1:0]            w_idx_nx;
    digit_t [3:0]          w_reg_nx;
    logic [6:0]            w_glyph;
    logic                  w_lz_blank;

    // Register file after this edge's write; the glyph is decoded from it so a
    // write to the lit digit shows up right after the write edge.
    always_comb begin
        w_reg_nx = r_reg;
        if (bus.wr_en)
            w_reg_nx[bus.wr_addr] = bus.wr_data;
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_idx_nx   = r_idx;
        if (!bus.en) begin
            w_state_nx = BLANK;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
        end else begin
            case (r_state)
                BLANK: if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                    w_state_nx = SHOW;
                    w_cnt_nx   = '0;
                end
                SHOW: if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    w_state_nx = BLANK;
                    w_cnt_nx   = '0;
                    w_idx_nx   = r_idx + 2'd1;
                end
                default: begin
                    w_state_nx = BLANK;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    seg7_hex_decode u_dec (
        .i_digit (w_reg_nx[w_idx_nx]),
        .o_seg   (w_glyph)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        w_lz_blank = 1'b0;
        case (w_idx_nx)
            2'd3: w_lz_blank = (w_reg_nx[3] == 4'h0);
            2'd2: w_lz_blank = (w_reg_nx[3] == 4'h0) && (w_reg_nx[2] == 4'h0);
            2'd1: w_lz_blank = (w_reg_nx[3] == 4'h0) && (w_reg_nx[2] == 4'h0)
                            && (w_reg_nx[1] == 4'h0);
            default: w_lz_blank = 1'b0;   // rightmost digit always shown
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // Outputs are registered from next-state values so pins move on the same
    // edge as the state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= BLANK;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_reg          <= '0;
            bus.an         <= AN_OFF;
            bus.seg        <= SEG_OFF;
            bus.dp         <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_reg   <= w_reg_nx;
            if (w_state_nx == SHOW) begin
                bus.an  <= ~(4'b0001 << w_idx_nx);
                bus.seg <= w_lz_blank ? SEG_OFF : w_glyph;
                bus.dp  <= ~bus.dp_mask[w_idx_nx];
            end else begin
                bus.an  <= AN_OFF;
                bus.seg <= SEG_OFF;
                bus.dp  <= 1'b1;
            end
            bus.frame_tick <= (w_state_nx == SHOW) && (r_state == BLANK)
                              && (w_idx_nx == 2'd0);
        end
    end

    assign bus.digit_idx = r_idx;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed test of seg_scan_ctrl with REFRESH_DIV=4,
// BLANK_CYC=2 (frame = 24 cycles). Inputs change on the falling edge and
// outputs are sampled there too, so each step() observes the state right
// after one rising edge.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    // Advance until frame_tick is seen, with a bounded budget.
    task automatic wait_tick(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_tick && n < 40);
        chk(tag, 16'(bus.frame_tick), 16'd1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.en      = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 4'h0;
        bus.dp_mask = 4'b0000;

        // Reset state
        #1;
        chk("rst_an",  16'(bus.an), 16'hF);
        chk("rst_seg", 16'(bus.seg), 16'h7F);
        chk("rst_dp",  16'(bus.dp), 16'd1);
        chk("rst_ft",  16'(bus.frame_tick), 16'd0);
        chk("rst_idx", 16'(bus.digit_idx), 16'd0);

        // 1: first scan after reset release
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t1_blank_an", 16'(bus.an), 16'hF);
        step();
        chk("t1_show_an",  16'(bus.an), 16'hE);
        chk("t1_show_seg", 16'(bus.seg), 16'(7'b0000001));
        chk("t1_ft_on",    16'(bus.frame_tick), 16'd1);
        step();
        chk("t1_ft_off",   16'(bus.frame_tick), 16'd0);
        chk("t1_hold_an1", 16'(bus.an), 16'hE);
        step(); step();
        chk("t1_hold_an3", 16'(bus.an), 16'hE);
        step();
        chk("t1_gap_an",   16'(bus.an), 16'hF);
        chk("t1_gap_idx",  16'(bus.digit_idx), 16'd1);
        step();
        chk("t1_gap2_an",  16'(bus.an), 16'hF);
        step();
        chk("t1_d1_an",    16'(bus.an), 16'hD);

        // 2: full frame with distinct glyphs
        wr(2'd3, 4'hF);
        wr(2'd2, 4'h8);
        wr(2'd1, 4'hA);
        wr(2'd0, 4'h1);
        wait_tick("t2_tick");
        chk("t2_d0_an",  16'(bus.an), 16'hE);
        chk("t2_d0_seg", 16'(bus.seg), 16'(7'b1001111));
        repeat (6) step();
        chk("t2_d1_an",  16'(bus.an), 16'hD);
        chk("t2_d1_seg", 16'(bus.seg), 16'(7'b0001000));
        repeat (6) step();
        chk("t2_d2_an",  16'(bus.an), 16'hB);
        chk("t2_d2_seg", 16'(bus.seg), 16'(7'b0000000));
        repeat (6) step();
        chk("t2_d3_an",  16'(bus.an), 16'h7);
        chk("t2_d3_seg", 16'(bus.seg), 16'(7'b0111000));
        repeat (6) step();
        chk("t2_period", 16'(bus.frame_tick), 16'd1);
        chk("t2_wrap_an", 16'(bus.an), 16'hE);

        // 3: write the lit digit
        wr(2'd0, 4'h5);
        chk("t3_seg_new", 16'(bus.seg), 16'(7'b0100100));
        chk("t3_an",      16'(bus.an), 16'hE);
        step(); step();
        chk("t3_an_hold", 16'(bus.an), 16'hE);
        step();
        chk("t3_an_off",  16'(bus.an), 16'hF);

        // 4: drop en mid digit 2
        step(); step();
        chk("t4_d1_an", 16'(bus.an), 16'hD);
        repeat (6) step();
        chk("t4_d2_an", 16'(bus.an), 16'hB);
        step();
        bus.en = 1'b0;
        step();
        chk("t4_off_an",  16'(bus.an), 16'hF);
        chk("t4_off_idx", 16'(bus.digit_idx), 16'd0);
        chk("t4_off_seg", 16'(bus.seg), 16'h7F);
        step(); step();
        chk("t4_off3_an", 16'(bus.an), 16'hF);
        bus.en = 1'b1;
        step();
        chk("t4_re_blank", 16'(bus.an), 16'hF);
        step();
        chk("t4_re_an",  16'(bus.an), 16'hE);
        chk("t4_re_seg", 16'(bus.seg), 16'(7'b0100100));
        chk("t4_re_ft",  16'(bus.frame_tick), 16'd1);

        // 5: decimal point on digit 2 only
        bus.dp_mask = 4'b0100;
        step();
        chk("t5_dp_d0", 16'(bus.dp), 16'd1);
        step(); step(); step();
        chk("t5_blank_an", 16'(bus.an), 16'hF);
        chk("t5_dp_blank", 16'(bus.dp), 16'd1);
        step(); step();
        chk("t5_d1_an", 16'(bus.an), 16'hD);
        chk("t5_dp_d1", 16'(bus.dp), 16'd1);
        repeat (4) step();
        step(); step();
        chk("t5_d2_an",  16'(bus.an), 16'hB);
        chk("t5_dp_d2",  16'(bus.dp), 16'd0);
        chk("t5_d2_seg", 16'(bus.seg), 16'(7'b0000000));
        repeat (3) step();
        chk("t5_dp_d2b", 16'(bus.dp), 16'd0);
        step();
        chk("t5_dp_blank2", 16'(bus.dp), 16'd1);
        bus.dp_mask = 4'b0000;

        // 6: leading-zero handling (result depends on the build macro)
        wr(2'd3, 4'h0);
        wr(2'd2, 4'h0);
        wr(2'd1, 4'h7);
        wr(2'd0, 4'h3);
        wait_tick("t6_tick");
        chk("t6_d0_an",  16'(bus.an), 16'hE);
        chk("t6_d0_seg", 16'(bus.seg), 16'(7'b0000110));
        repeat (6) step();
        chk("t6_d1_an",  16'(bus.an), 16'hD);
        chk("t6_d1_seg", 16'(bus.seg), 16'(7'b0001111));
        repeat (6) step();
        chk("t6_d2_an",  16'(bus.an), 16'hB);
        chk("t6_d2_seg", 16'(bus.seg), LZ ? 16'h7F : 16'(7'b0000001));
        repeat (6) step();
        chk("t6_d3_an",  16'(bus.an), 16'h7);
        chk("t6_d3_seg", 16'(bus.seg), LZ ? 16'h7F : 16'(7'b0000001));
        wr(2'd1, 4'h0);
        wr(2'd0, 4'h0);
        wait_tick("t6_tick2");
        chk("t6_z_d0_seg", 16'(bus.seg), 16'(7'b0000001));
        chk("t6_z_d0_an",  16'(bus.an), 16'hE);
        repeat (6) step();
        chk("t6_z_d1_an",  16'(bus.an), 16'hD);
        chk("t6_z_d1_seg", 16'(bus.seg), LZ ? 16'h7F : 16'(7'b0000001));

        // Reset asserted mid-SHOW: dark at once, registers cleared
        wr(2'd0, 4'h9);
        rst = 1'b1;
        #1;
        chk("r_async_an",  16'(bus.an), 16'hF);
        chk("r_async_seg", 16'(bus.seg), 16'h7F);
        chk("r_async_dp",  16'(bus.dp), 16'd1);
        @(negedge clk);
        rst = 1'b0;
        step(); step();
        chk("r_post_an",  16'(bus.an), 16'hE);
        chk("r_post_seg", 16'(bus.seg), 16'(7'b0000001));
        chk("r_post_ft",  16'(bus.frame_tick), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. Holds four 4-bit digit registers written through a simple write port. Cycles one active-low anode at a time with a dead-time blanking gap between digits to suppress ghosting. Drives the active-low segments with the hex glyph of the selected digit. Replaces manual digit selection with an automatic refresh sequencer.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is lit (SHOW phase); must be >= 2
BLANK_CYC, 16, clk cycles all anodes are off between digits (BLANK phase); must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  display enable; low forces the display dark and restarts the scan
wr_en  input  1  write strobe, sampled on the rising edge of clk
wr_addr  input  2  digit register index to write (0 = rightmost digit)
wr_data  input  4  hex value to store
dp_mask  input  4  per-digit decimal point request, active-high, bit i = digit i
seg  output  7  segments {A,B,C,D,E,F,G}, active-low
dp  output  1  decimal point, active-low
an  output  4  anodes, active-low, an[i] = digit i
digit_idx  output  2  index of the digit currently being scanned
frame_tick  output  1  one-cycle pulse at the start of each full 4-digit frame

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values:
  - digit registers = 0, state = BLANK, phase counter = 0, digit_idx = 0
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0
- Output timing: all outputs are registered and are computed from next-state logic, so they change on the same edge as the state transition.
- FSM states: BLANK, SHOW.
  - BLANK: an = 1111, seg = 1111111, dp = 1. Lasts BLANK_CYC cycles, counter 0..BLANK_CYC-1. Then go to SHOW and clear the counter.
  - SHOW: an[digit_idx] = 0 and all other anodes = 1. seg = glyph(reg[digit_idx]). dp = ~dp_mask[digit_idx]. Lasts REFRESH_DIV cycles. Then go to BLANK, clear the counter, and set digit_idx = digit_idx + 1 (mod 4, wraps 3 -> 0).
- frame_tick: asserted for exactly one cycle on the edge that enters SHOW with digit_idx = 0.
- Glyphs (standard hex, active-low {A..G}):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Writes: reg[wr_addr] <= wr_data on the clk edge with wr_en = 1. Writes are accepted in any state and regardless of en.
  - If the written digit is currently in SHOW, seg shows the new glyph starting the cycle after the write edge.
- en = 0 (takes effect the cycle after sampling):
  - state forced to BLANK, counter and digit_idx cleared, outputs dark, frame_tick = 0
  - digit registers keep their contents
- en 0 -> 1: the scan restarts exactly as after reset. The first anode (an[0]) goes low BLANK_CYC cycles after en is first sampled high.
- dp_mask changes: take effect the next cycle while in SHOW. dp is forced to 1 during BLANK.
- Reset asserted mid-SHOW: outputs go dark immediately (asynchronously) and the digit registers clear.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN
- Defined: during SHOW of digit i (i = 3, 2, 1), seg is forced to 1111111 when reg[i] and every more-significant register are all 0.
  - Digit 0 is never suppressed.
  - dp still follows dp_mask.
  - The anode timing is unchanged.
- Undefined: every digit always shows its glyph.

Decomposition:
- Package seg_pkg holds:
  - typedef enum logic {BLANK, SHOW} scan_state_t
  - constants SEG_OFF = 7'b1111111 and AN_OFF = 4'b1111
  - typedef logic [3:0] digit_t
- One sub-module: seg7_hex_decode, a purely combinational 4-bit to active-low 7-segment decoder, instantiated once on the selected digit.

Test Plan (REFRESH_DIV = 4, BLANK_CYC = 2 unless stated):
1. Reset release with en = 1 and registers cleared -> outputs dark for 2 cycles; then an = 1110, seg = 0000001, frame_tick = 1 for one cycle; SHOW holds 4 cycles; 2 dark cycles; then an = 1101.
2. Write 3, 2, 1, 0 <- 4'hF, 4'h8, 4'hA, 4'h1 -> the scan shows 1001111, 0001000, 0000000, 0111000 on an = 1110, 1101, 1011, 0111; frame_tick recurs every 24 cycles.
3. Write digit 0 <- 4'h5 while an = 1110 -> seg becomes 0100100 one cycle after the write edge; an timing is unchanged.
4. Drop en for 3 cycles in the middle of digit 2 -> an = 1111 and digit_idx = 0; re-raise en -> an = 1110 after 2 cycles; register contents are preserved.
5. dp_mask = 0100 -> dp = 0 only while an = 1011; dp = 1 during BLANK.
6. Macro defined, registers {0, 0, 7, 3} (digit 3 .. digit 0) -> digits 3 and 2 show seg = 1111111 with their anodes still pulsing; digits 1 and 0 show 0001111 and 0000110; with all registers 0, digit 0 still shows 0000001.
